ysyx_22040729_ifu: RTL and testbench

- Instruction fetch unit that sits directly upstream of the instruction decoder.
- Holds the architectural PC and issues one outstanding fetch at a time to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents each fetched instruction word, with its PC, to the decoder through a valid/ready handshake.
- Accepts PC redirects from execute (branches/jumps) and discards any fetch in flight when a redirect arrives.

---
 rtl/ysyx_22040729_ifu_if.sv | 30 +++
 rtl/ysyx_22040729_ifu.sv | 97 +++++++++
 tb/tb_ysyx_22040729_ifu.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040729_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decoder handoff and
// execute redirect. The IFU takes the master side; memory/decoder/execute take slave.
interface ysyx_22040729_ifu_if #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst_out;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_22040729_ifu.sv
// Instruction fetch unit: one outstanding memory fetch at a time, hands each word
// and its PC to the decoder, and discards in-flight work on an execute redirect.
module ysyx_22040729_ifu #(
  parameter int                    INST_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_22040729_ifu_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_n;
  logic [ADDR_WIDTH-1:0] inst_pc_q;
  logic [ADDR_WIDTH-1:0] inst_pc_n;
  logic [INST_WIDTH-1:0] inst_out_q;
  logic [INST_WIDTH-1:0] inst_out_n;
  logic                  inst_valid_q;
  logic                  inst_valid_n;
  logic                  outstanding;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      inst_pc_q    <= '0;
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      inst_pc_q    <= inst_pc_n;
      inst_out_q   <= inst_out_n;
      inst_valid_q <= inst_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    inst_pc_n    = inst_pc_q;
    inst_out_n   = inst_out_q;
    inst_valid_n = inst_valid_q;
    // A response is still owed to us if it was just accepted or we are waiting on it.
    outstanding  = ((state == S_WAIT) && !bus.imem_rsp_valid) ||
                   ((state == S_REQ) && bus.imem_req_ready);

    if (bus.redirect_valid) begin
      pc_n         = bus.redirect_pc & ~ADDR_WIDTH'(3);
      inst_valid_n = 1'b0;
      state_n      = outstanding ? S_DRAIN : S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.imem_req_ready) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            inst_out_n   = bus.imem_rsp_data;
            inst_pc_n    = pc;
            inst_valid_n = 1'b1;
            pc_n         = pc + ADDR_WIDTH'(4);
            state_n      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.inst_ready) begin
            inst_valid_n = 1'b0;
            state_n      = S_REQ;
          end
        end
        S_DRAIN: begin
          if (bus.imem_rsp_valid) state_n = S_REQ;
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  // Request strobe is purely a function of state so the decoder's ready cannot reach it.
  assign bus.imem_req_valid = (state == S_REQ) && !rst;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst_out       = inst_out_q;
  assign bus.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22040729_ifu.sv
// Bench for ysyx_22040729_ifu: directed scenarios plus a randomized run checked
// against a transaction-level model of the expected instruction stream.
module tb_ysyx_22040729_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  ysyx_22040729_ifu_if #(.INST_WIDTH(32), .ADDR_WIDTH(64)) bus ();

  ysyx_22040729_ifu #(
    .INST_WIDTH(32),
    .ADDR_WIDTH(64),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: each address maps to a distinct-looking word.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  task automatic drive_idle();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_req_valid got=%0b exp=0", bus.imem_req_valid); end
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_inst_valid got=%0b exp=0", bus.inst_valid); end
    tests_run++; if (bus.inst_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_inst_out got=%h exp=0", bus.inst_out); end
    tests_run++; if (bus.inst_pc !== 64'h0) begin tests_failed++; $display("[TB] FAIL rst_inst_pc got=%h exp=0", bus.inst_pc); end
    tests_run++; if (bus.imem_req_addr !== RST_PC) begin tests_failed++; $display("[TB] FAIL rst_addr got=%h exp=%h", bus.imem_req_addr, RST_PC); end
    rst = 1'b0;
    #1;
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rel_req_valid got=%0b exp=1", bus.imem_req_valid); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ff_req_valid got=%0b exp=1", bus.imem_req_valid); end
    tests_run++; if (bus.imem_req_addr !== RST_PC) begin tests_failed++; $display("[TB] FAIL ff_addr got=%h exp=%h", bus.imem_req_addr, RST_PC); end
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ff_wait_req got=%0b exp=0", bus.imem_req_valid); end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0513;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ff_inst_valid got=%0b exp=1", bus.inst_valid); end
    tests_run++; if (bus.inst_out !== 32'h0000_0513) begin tests_failed++; $display("[TB] FAIL ff_inst_out got=%h exp=00000513", bus.inst_out); end
    tests_run++; if (bus.inst_pc !== RST_PC) begin tests_failed++; $display("[TB] FAIL ff_inst_pc got=%h exp=%h", bus.inst_pc, RST_PC); end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ff_next_req got=%0b exp=1", bus.imem_req_valid); end
    tests_run++; if (bus.imem_req_addr !== RST_PC + 64'd4) begin tests_failed++; $display("[TB] FAIL ff_next_addr got=%h exp=%h", bus.imem_req_addr, RST_PC + 64'd4); end
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ff_consumed got=%0b exp=0", bus.inst_valid); end
  endtask

  // Continues from the state left by test_first_fetch (requesting RST_PC+4).
  task automatic test_hold_stall();
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hdead_beef;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_valid[%0d] got=%0b exp=1", i, bus.inst_valid); end
      tests_run++; if (bus.inst_out !== 32'hdead_beef) begin tests_failed++; $display("[TB] FAIL hold_out[%0d] got=%h exp=deadbeef", i, bus.inst_out); end
      tests_run++; if (bus.inst_pc !== RST_PC + 64'd4) begin tests_failed++; $display("[TB] FAIL hold_pc[%0d] got=%h exp=%h", i, bus.inst_pc, RST_PC + 64'd4); end
      tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_req[%0d] got=%0b exp=0", i, bus.imem_req_valid); end
      @(negedge clk);
    end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_rel_req got=%0b exp=1", bus.imem_req_valid); end
    tests_run++; if (bus.imem_req_addr !== RST_PC + 64'd8) begin tests_failed++; $display("[TB] FAIL hold_rel_addr got=%h exp=%h", bus.imem_req_addr, RST_PC + 64'd8); end
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_rel_valid got=%0b exp=0", bus.inst_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_8000_1002;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_drain_req[%0d] got=%0b exp=0", i, bus.imem_req_valid); end
      tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_drain_valid[%0d] got=%0b exp=0", i, bus.inst_valid); end
      if (i == 2) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0bad_0bad;
      end
      @(negedge clk);
    end
    bus.imem_rsp_valid = 1'b0;
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_dropped got=%0b exp=0", bus.inst_valid); end
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rw_req got=%0b exp=1", bus.imem_req_valid); end
    tests_run++; if (bus.imem_req_addr !== 64'h0000_0000_8000_1000) begin tests_failed++; $display("[TB] FAIL rw_addr got=%h exp=0000000080001000", bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0010_0113;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    tests_run++; if (bus.inst_pc !== 64'h0000_0000_8000_1000) begin tests_failed++; $display("[TB] FAIL rw_new_pc got=%h exp=0000000080001000", bus.inst_pc); end
    tests_run++; if (bus.inst_out !== 32'h0010_0113) begin tests_failed++; $display("[TB] FAIL rw_new_out got=%h exp=00100113", bus.inst_out); end
  endtask

  task automatic test_redirect_accept();
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_8000_2000;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ra_drain_req got=%0b exp=0", bus.imem_req_valid); end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h5a5a_5a5a;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ra_stale got=%0b exp=0", bus.inst_valid); end
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ra_req got=%0b exp=1", bus.imem_req_valid); end
    tests_run++; if (bus.imem_req_addr !== 64'h0000_0000_8000_2000) begin tests_failed++; $display("[TB] FAIL ra_addr got=%h exp=0000000080002000", bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0010_0093;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ra_valid got=%0b exp=1", bus.inst_valid); end
    tests_run++; if (bus.inst_pc !== 64'h0000_0000_8000_2000) begin tests_failed++; $display("[TB] FAIL ra_pc got=%h exp=0000000080002000", bus.inst_pc); end
    tests_run++; if (bus.inst_out !== 32'h0010_0093) begin tests_failed++; $display("[TB] FAIL ra_out got=%h exp=00100093", bus.inst_out); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hffff_ffff_ffff_ffff;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    tests_run++; if (bus.imem_req_addr !== 64'hffff_ffff_ffff_fffc) begin tests_failed++; $display("[TB] FAIL wrap_addr got=%h exp=fffffffffffffffc", bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0013;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    tests_run++; if (bus.inst_pc !== 64'hffff_ffff_ffff_fffc) begin tests_failed++; $display("[TB] FAIL wrap_pc got=%h exp=fffffffffffffffc", bus.inst_pc); end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_req got=%0b exp=1", bus.imem_req_valid); end
    tests_run++; if (bus.imem_req_addr !== 64'h0) begin tests_failed++; $display("[TB] FAIL wrap_next got=%h exp=0", bus.imem_req_addr); end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1234_5678;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rh_pre got=%0b exp=1", bus.inst_valid); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rh_valid got=%0b exp=0", bus.inst_valid); end
    tests_run++; if (bus.inst_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL rh_out got=%h exp=0", bus.inst_out); end
    tests_run++; if (bus.inst_pc !== 64'h0) begin tests_failed++; $display("[TB] FAIL rh_pc got=%h exp=0", bus.inst_pc); end
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rh_req got=%0b exp=0", bus.imem_req_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rh_rel_req got=%0b exp=1", bus.imem_req_valid); end
    tests_run++; if (bus.imem_req_addr !== RST_PC) begin tests_failed++; $display("[TB] FAIL rh_rel_addr got=%h exp=%h", bus.imem_req_addr, RST_PC); end
  endtask

  // Random memory latency, decoder stalls and redirects. The model only tracks the
  // PC the next consumed instruction must carry; requests must ask for that PC too.
  task automatic test_random();
    logic [63:0] exp_pc;
    logic [63:0] mem_addr;
    logic [63:0] tgt;
    logic        mem_busy;
    int          mem_delay;
    logic        drain_pending;
    logic        rsp_now, rdy, ir, redir, accept, consume;
    logic        rv, iv;
    logic [63:0] ra, ip;
    logic [31:0] io;
    int          delivered;

    do_reset();
    @(negedge clk);
    exp_pc        = RST_PC;
    mem_busy      = 1'b0;
    mem_delay     = 0;
    mem_addr      = '0;
    drain_pending = 1'b0;
    delivered     = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rv = bus.imem_req_valid;
      ra = bus.imem_req_addr;
      iv = bus.inst_valid;
      io = bus.inst_out;
      ip = bus.inst_pc;

      rsp_now = 1'b0;
      if (mem_busy) begin
        mem_delay--;
        rsp_now = (mem_delay == 0);
      end
      rdy   = ($urandom_range(0, 3) != 0);
      ir    = ($urandom_range(0, 2) != 0);
      redir = !drain_pending && ($urandom_range(0, 15) == 0);
      tgt   = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 0) tgt[63:32] = 32'h0;

      bus.imem_req_ready = rdy;
      bus.imem_rsp_valid = rsp_now;
      bus.imem_rsp_data  = rsp_now ? mem_word(mem_addr) : 32'h0;
      bus.inst_ready     = ir;
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;

      accept  = rv && rdy;
      consume = iv && ir && !redir;

      if (rv && mem_busy) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL rnd_second_outstanding cyc=%0d got req_valid=1 exp=0", cyc);
      end
      if (consume) begin
        tests_run++; if (ip !== exp_pc) begin tests_failed++; $display("[TB] FAIL rnd_inst_pc cyc=%0d got=%h exp=%h", cyc, ip, exp_pc); end
        tests_run++; if (io !== mem_word(exp_pc)) begin tests_failed++; $display("[TB] FAIL rnd_inst_out cyc=%0d got=%h exp=%h", cyc, io, mem_word(exp_pc)); end
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
      if (accept && !redir) begin
        tests_run++; if (ra !== exp_pc) begin tests_failed++; $display("[TB] FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, ra, exp_pc); end
      end
      if (rsp_now && drain_pending) drain_pending = 1'b0;
      if (redir) begin
        if ((mem_busy && !rsp_now) || accept) drain_pending = 1'b1;
        exp_pc = {tgt[63:2], 2'b00};
      end
      if (rsp_now) mem_busy = 1'b0;
      if (accept) begin
        mem_busy  = 1'b1;
        mem_delay = $urandom_range(1, 3);
        mem_addr  = ra;
      end
      @(negedge clk);
    end
    drive_idle();
    tests_run++; if (delivered < 100) begin tests_failed++; $display("[TB] FAIL rnd_throughput got=%0d exp>=100", delivered); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    drive_idle();
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_accept();
    test_wrap();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
